// File: rtl/pattern_pkg.sv
// Shared constants for the keyword transmitter: keyword bytes, FSM states, field widths.
package pattern_pkg;

   localparam int PAT_LEN = 5;
   localparam int GAP_W   = 4;
   localparam int REP_W   = 8;
   localparam int IDX_W   = 3;

   localparam logic [7:0] IDLE_BYTE = 8'h00;

   // Keyword "state"; element 0 is transmitted first.
   localparam logic [0:PAT_LEN-1][7:0] PATTERN = {8'h73, 8'h74, 8'h61, 8'h74, 8'h65};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/pattern_tx_if.sv
// Byte stream with valid/ready handshake between the transmitter and its consumer.
interface pattern_tx_if;

   logic [7:0] data;
   logic       data_vld;
   logic       data_rdy;

   modport master (output data, output data_vld, input data_rdy);
   modport slave  (input data, input data_vld, output data_rdy);

endinterface

// File: rtl/pattern_rom.sv
// Combinational index-to-byte lookup of the keyword; out-of-range indices return the idle byte.
module pattern_rom
   import pattern_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [7:0]       pat_byte
);

   // Keyword table lookup
   always_comb begin
      pat_byte = IDLE_BYTE;
      if (idx < IDX_W'(PAT_LEN)) begin
         pat_byte = PATTERN[idx];
      end else begin
         pat_byte = IDLE_BYTE;
      end
   end

endmodule

// File: rtl/pattern_tx.sv
// Keyword transmitter: sends the package keyword repeat_cnt times with gap idle
// cycles after every accepted byte except the last, then pulses done.
module pattern_tx
   import pattern_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [REP_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap,
   pattern_tx_if.master     strm,
   output logic             busy,
   output logic             done
);

   state_t           state_r;
   logic [IDX_W-1:0] idx_r;
   logic [REP_W-1:0] rep_r;
   logic [REP_W-1:0] rep_lim_r;
   logic [GAP_W-1:0] gap_r;
   logic [GAP_W-1:0] gcnt_r;
   logic [7:0]       data_r;
   logic             vld_r;

   logic             hs_s;
   logic             last_s;
   logic             wrap_s;
   logic [IDX_W-1:0] idx_nxt_s;
   logic [IDX_W-1:0] rom_idx_s;
   logic [7:0]       rom_byte_s;

   assign strm.data     = data_r;
   assign strm.data_vld = vld_r;

   pattern_rom u_rom (
      .idx      (rom_idx_s),
      .pat_byte (rom_byte_s)
   );

   // ROM is addressed with the byte that becomes visible after the next edge
   always_comb begin
      hs_s      = 1'b0;
      last_s    = 1'b0;
      wrap_s    = 1'b0;
      idx_nxt_s = {IDX_W{1'b0}};
      rom_idx_s = {IDX_W{1'b0}};
      hs_s      = (state_r == SEND) && strm.data_rdy;
      wrap_s    = (idx_r == IDX_W'(PAT_LEN - 1));
      last_s    = wrap_s && (rep_r == rep_lim_r);
      if (wrap_s) begin
         idx_nxt_s = {IDX_W{1'b0}};
      end else begin
         idx_nxt_s = idx_r + IDX_W'(1);
      end
      case (state_r)
         SEND:    rom_idx_s = idx_nxt_s;
         GAP:     rom_idx_s = idx_r;
         default: rom_idx_s = {IDX_W{1'b0}};
      endcase
   end

   // Transmit FSM with counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         idx_r     <= {IDX_W{1'b0}};
         rep_r     <= {REP_W{1'b0}};
         rep_lim_r <= {REP_W{1'b0}};
         gap_r     <= {GAP_W{1'b0}};
         gcnt_r    <= {GAP_W{1'b0}};
         data_r    <= IDLE_BYTE;
         vld_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  rep_lim_r <= repeat_cnt;
                  gap_r     <= gap;
                  idx_r     <= {IDX_W{1'b0}};
                  rep_r     <= REP_W'(1);
                  if (repeat_cnt == {REP_W{1'b0}}) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end else begin
                     state_r <= SEND;
                     busy    <= 1'b1;
                     vld_r   <= 1'b1;
                     data_r  <= rom_byte_s;
                  end
               end
            end
            SEND: begin
               if (hs_s) begin
                  if (last_s) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     vld_r   <= 1'b0;
                     data_r  <= IDLE_BYTE;
                  end else begin
                     idx_r <= idx_nxt_s;
                     if (wrap_s) begin
                        rep_r <= rep_r + REP_W'(1);
                     end
                     if (gap_r != {GAP_W{1'b0}}) begin
                        state_r <= GAP;
                        gcnt_r  <= gap_r;
                        vld_r   <= 1'b0;
                        data_r  <= IDLE_BYTE;
                     end else begin
                        data_r  <= rom_byte_s;
                     end
                  end
               end
            end
            GAP: begin
               if (gcnt_r == GAP_W'(1)) begin
                  state_r <= SEND;
                  gcnt_r  <= {GAP_W{1'b0}};
                  vld_r   <= 1'b1;
                  data_r  <= rom_byte_s;
               end else begin
                  gcnt_r  <= gcnt_r - GAP_W'(1);
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               vld_r   <= 1'b0;
               data_r  <= IDLE_BYTE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized bench for pattern_tx: each transaction is compared against the byte
// sequence "state" x repeat_cnt, the gap length between bytes, and done timing.
module tb_pattern_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] repeat_cnt;
   logic [3:0] gap;
   logic       busy;
   logic       done;

   int n_chk  = 0;
   int n_pass = 0;

   string kw_s = "state";

   pattern_tx_if bus ();

   pattern_tx dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .repeat_cnt (repeat_cnt),
      .gap        (gap),
      .strm       (bus),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transmission: r repeats, gap g, ready probability pct, optional
   // 3-cycle stall on the first 8'h74, optional ignored start mid-stream.
   task automatic run_txn(input int r, input int g, input int pct, input bit bp, input bit poke);
      logic [7:0] exp_q [$];
      logic [7:0] seen_q [$];
      int  got       = 0;
      int  idle      = 0;
      int  stall     = 0;
      int  cyc       = 0;
      int  last_hs   = -1;
      int  kw_cnt    = 0;
      int  budget;
      bit  need_gap  = 1'b0;
      bit  fin       = 1'b0;
      bit  match;
      for (int k = 0; k < r; k++)
         for (int j = 0; j < 5; j++)
            exp_q.push_back(kw_s[j]);
      budget = 40 + 5 * r * (g + 1) + 5 * r * 40;
      @(posedge clk); #1;
      start = 1'b1; repeat_cnt = r[7:0]; gap = g[3:0];
      @(posedge clk); #1;
      start = 1'b0;
      while (!fin && cyc < budget) begin
         @(negedge clk);
         if (bp && bus.data_vld && bus.data == 8'h74 && stall < 3) begin
            bus.data_rdy = 1'b0;
            stall++;
         end else begin
            bus.data_rdy = ($urandom_range(99) < pct);
         end
         if (poke && cyc == 2) begin
            start = 1'b1; repeat_cnt = 8'($urandom_range(0, 9)); gap = 4'($urandom_range(0, 15));
         end else begin
            start = 1'b0;
         end
         if (cyc == 0) check("first_vld", bus.data_vld, r > 0);
         if (bus.data_vld) begin
            if (need_gap) begin
               check("gap_len", idle, g);
               need_gap = 1'b0;
            end
            if (got < exp_q.size()) check("byte", bus.data, exp_q[got]);
            else check("extra_byte", got, exp_q.size());
            check("busy_tx", busy, 1);
            if (bus.data_rdy) begin
               seen_q.push_back(bus.data);
               got++;
               last_hs  = cyc;
               need_gap = 1'b1;
               idle     = 0;
            end
         end else begin
            check("idle_data", bus.data, 0);
            if (need_gap) idle++;
         end
         if (done) begin
            check("done_when", cyc, last_hs + 1);
            check("done_bytes", got, r * 5);
            check("done_busy", busy, 0);
            check("done_vld", bus.data_vld, 0);
            start = 1'b0;
            repeat (2) begin
               @(negedge clk);
               check("post_done", {done, busy, bus.data_vld}, 0);
            end
            fin = 1'b1;
         end
         cyc++;
      end
      start = 1'b0;
      check("done_seen", fin, 1);
      for (int i = 0; i + 5 <= seen_q.size(); i++) begin
         match = 1'b1;
         for (int j = 0; j < 5; j++)
            if (seen_q[i + j] != kw_s[j]) match = 1'b0;
         if (match) kw_cnt++;
      end
      check("kw_count", kw_cnt, r);
   endtask

   initial begin
      bit found;
      rst = 1'b1; start = 1'b0; repeat_cnt = 8'd0; gap = 4'd0; bus.data_rdy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out", {bus.data, bus.data_vld, busy, done}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset during the third byte of a transmission
      @(posedge clk); #1;
      start = 1'b1; repeat_cnt = 8'd1; gap = 4'd0; bus.data_rdy = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.data_vld && bus.data == 8'h61) found = 1'b1;
      end
      check("saw_61", found, 1);
      #2 rst = 1'b1;
      #1 check("rst_mid", {bus.data, bus.data_vld, busy, done}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_idle", {bus.data, bus.data_vld, busy, done}, 0);

      run_txn(1, 0, 100, 1'b0, 1'b0);
      run_txn(2, 2, 100, 1'b0, 1'b0);
      run_txn(1, 0, 100, 1'b1, 1'b0);
      run_txn(0, 0, 100, 1'b0, 1'b0);
      run_txn(2, 1, 100, 1'b0, 1'b1);
      run_txn(3, 0, 100, 1'b0, 1'b0);
      run_txn(1, 15, 100, 1'b0, 1'b0);
      run_txn(255, 0, 100, 1'b0, 1'b0);
      for (int t = 0; t < 12; t++) begin
         run_txn($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(30, 100),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Byte-stream pattern transmitter for the mean_filter sequence-detection path. On a start pulse it emits the ASCII keyword "state" (8'h73 74 61 74 65) one byte per beat on a valid/ready stream, with a programmable idle gap between bytes and a programmable repeat count. It drives the data input of the `fsm` keyword detector in system-level benches and on-board self-test, and idles at 8'h00 between transmissions.

## Interface
- `PAT_LEN`, 5: keyword length in bytes; fixed by the package constant.
- `GAP_W`, 4: width of `gap`.
- `REP_W`, 8: width of `repeat_cnt`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `repeat_cnt` in REP_W: number of full keyword transmissions; latched on accepted start.
- `gap` in GAP_W: idle cycles inserted after every accepted byte except the last; latched on accepted start.
- `data_rdy` in 1: downstream ready.
- `data` out 8: current byte; 8'h00 whenever `data_vld`=0.
- `data_vld` out 1: byte valid.
- `busy` out 1: transmission in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- All outputs are registered. Reset drives `data`=0, `data_vld`=0, `busy`=0, `done`=0, state=IDLE, and clears the index, repeat, and gap counters. Reset is effective immediately, including mid-transmission, and no partial keyword resumes.
- States:
  - IDLE: `start`=1 latches `repeat_cnt` and `gap`.
    - If the latched `repeat_cnt`=0, go to DONE with no bytes sent.
    - Otherwise set idx=0, rep=1, and go to SEND.
  - SEND: `data`=pattern[idx], `data_vld`=1. Hold both stable while `data_rdy`=0. On `vld&rdy` one of the following applies:
    - Last byte of the last repetition (idx=PAT_LEN-1, rep=repeat_cnt): go to DONE.
    - Otherwise, if gap>0: go to GAP with gcnt=gap. The index advances, wrapping to 0 and incrementing rep after idx=PAT_LEN-1.
    - Otherwise (gap=0): stay in SEND with the advanced index (back-to-back bytes).
  - GAP: `data_vld`=0, `data`=0. Decrement gcnt and return to SEND when it reaches 1.
  - DONE: `done`=1 for exactly one cycle, `busy`=0, then IDLE.
- `busy`=1 in SEND and GAP only.
- `start` in any state other than IDLE is ignored, not queued.
- `data_rdy` is ignored when `data_vld`=0.
- The index wraps modulo PAT_LEN. The rep counter is REP_W bits wide and never overflows because it stops at `repeat_cnt`.

## Timing
- Accepted start at edge N → first byte 8'h73 visible with `data_vld`=1 after edge N+1 (latency 1).
- Throughput with gap=0 and `data_rdy`=1: one byte per cycle. One keyword takes 5 cycles; R repeats take 5R cycles.
- With gap=g: each accepted byte is followed by g cycles of `data_vld`=0. A byte is held for as long as ready is low.
- `done` rises on the edge after the final handshake. A new start is accepted at the earliest 1 cycle after `done`, i.e. in IDLE.
- `repeat_cnt`=0: `done` pulses on the edge after start, with no `data_vld`.
- `repeat_cnt`/`gap` changes during `busy` have no effect.

## Structure
- Package `pattern_pkg` holds:
  - `PAT_LEN`;
  - the keyword byte array (8'h73,8'h74,8'h61,8'h74,8'h65);
  - the state enum {IDLE, SEND, GAP, DONE};
  - `IDLE_BYTE`=8'h00.
- One sub-module, `pattern_rom`: a combinational index→byte lookup from the package array, so other keywords can be swapped in.
- The FSM and counters live in `pattern_tx`.

## Test plan
- Reset mid-stream: assert `rst` during the 3rd byte (8'h61) → all outputs 0 on the same cycle. After release, `start`, `repeat_cnt`=1, gap=0 → bytes 73,74,61,74,65 on 5 consecutive cycles, then `done` for 1 cycle.
- Repeat with gap: `repeat_cnt`=2, gap=2, `data_rdy`=1 → 10 bytes with exactly 2 idle cycles (data 00) between consecutive bytes, none after the last, then `done`. Total 10+18 cycles from the first byte to `done`.
- Backpressure: hold `data_rdy`=0 for 3 cycles while 8'h74 is valid → `data` stays 74 and `vld` stays 1, and the following byte is 61. No byte is dropped or duplicated.
- `repeat_cnt`=0: `start` → `done` 1 cycle later, `data_vld` never asserted, `busy` stays 0.
- Start ignored: pulse `start` again during byte 2 with different `repeat_cnt`/`gap` → the original transmission finishes unchanged and exactly one `done` pulse occurs.
- End-to-end: pattern_tx → `fsm` (`data_vld` low sends 00) with `repeat_cnt`=3 → the detector `flag` asserts 3 times, once after each final 8'h65.
